// File: rtl/sobel_grad.sv
// Sobel edge detector: 3x3 window in, |Gx|+|Gy| pixel out, 3-stage stallable pipeline.
// Define SOBEL_THRESH_EN to binarise the output against THRESH.
module sobel_grad #(
  parameter int COLS   = 638,
  parameter int ROWS   = 478,
  parameter int THRESH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [71:0] win_in,
  input  logic        win_valid,
  output logic        win_ready,
  output logic [7:0]  pix_out,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_col,
  output logic [8:0]  pix_row,
  output logic        frame_done
);

  localparam logic [9:0] COL_LAST = 10'(COLS - 1);
  localparam logic [8:0] ROW_LAST = 9'(ROWS - 1);

  logic [7:0] p00, p10, p20, p01, p11, p21, p02, p12, p22;
  assign {p00, p10, p20, p01, p11, p21, p02, p12, p22} = win_in;

  logic stall, advance, xfer;
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [10:0] neg_gx, neg_gy, mag_d, mag_q;
  logic [9:0]  abs_gx, abs_gy;
  logic [7:0]  sat_mag, pix_d, pix_q;
  logic [9:0]  col_d, col_q;
  logic [8:0]  row_d, row_q;
  logic        frame_done_d, frame_done_q;

  // The whole pipeline freezes only when the output register holds an unaccepted pixel.
  assign stall     = s3_valid_q & ~pix_ready;
  assign advance   = ~stall;
  assign xfer      = s3_valid_q & pix_ready;
  assign win_ready = advance;

  // S1 inputs: each sum of positive / negative taps fits in 10 bits, difference in 11 signed.
  assign gx_pos = {3'b0, p02} + {2'b0, p12, 1'b0} + {3'b0, p22};
  assign gx_neg = {3'b0, p00} + {2'b0, p10, 1'b0} + {3'b0, p20};
  assign gy_pos = {3'b0, p20} + {2'b0, p21, 1'b0} + {3'b0, p22};
  assign gy_neg = {3'b0, p00} + {2'b0, p01, 1'b0} + {3'b0, p02};
  assign gx_d   = $signed(gx_pos - gx_neg);
  assign gy_d   = $signed(gy_pos - gy_neg);

  assign neg_gx = -gx_q;
  assign neg_gy = -gy_q;
  assign abs_gx = gx_q[10] ? neg_gx[9:0] : gx_q[9:0];
  assign abs_gy = gy_q[10] ? neg_gy[9:0] : gy_q[9:0];
  assign mag_d  = {1'b0, abs_gx} + {1'b0, abs_gy};

  assign sat_mag = (|mag_q[10:8]) ? 8'hFF : mag_q[7:0];
`ifdef SOBEL_THRESH_EN
  localparam logic [7:0] THRESH_L = 8'(THRESH);
  assign pix_d = (sat_mag >= THRESH_L) ? 8'hFF : 8'h00;
`else
  assign pix_d = sat_mag;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (xfer) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + 9'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s3_valid_q   <= 1'b0;
      pix_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (advance) begin
        s1_valid_q <= win_valid;
        s2_valid_q <= s1_valid_q;
        s3_valid_q <= s2_valid_q;
        pix_q      <= pix_d;
      end
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: interior datapath registers carry no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (advance) begin
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      mag_q <= mag_d;
    end
  end

  assign pix_out    = pix_q;
  assign pix_valid  = s3_valid_q;
  assign pix_col    = col_q;
  assign pix_row    = row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_grad.sv
// Self-checking bench for sobel_grad: vector table, directed stall/reset/frame sequences,
// and a random stream scored against a plain-arithmetic Sobel model.
module tb_sobel_grad;

  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int THRESH = 64;
  localparam int FRAME  = COLS * ROWS;
  localparam int NV     = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] win_in;
  logic        win_valid, win_ready;
  logic [7:0]  pix_out;
  logic        pix_valid, pix_ready;
  logic [9:0]  pix_col;
  logic [8:0]  pix_row;
  logic        frame_done;

  sobel_grad #(.COLS(COLS), .ROWS(ROWS), .THRESH(THRESH)) dut (
    .clk        (clk),
    .reset      (reset),
    .win_in     (win_in),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_col    (pix_col),
    .pix_row    (pix_row),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  int n_out     = 0;
  bit last_xfer = 1'b0;
  int fd_seen   = 0;

  typedef struct {
    logic [71:0] win;
    logic [7:0]  exp_mag;
    logic [7:0]  exp_thr;
  } vec_t;
  vec_t tab[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk(input int p00, p10, p20, p01, p11, p21, p02, p12, p22);
    return {8'(p00), 8'(p10), 8'(p20), 8'(p01), 8'(p11), 8'(p21), 8'(p02), 8'(p12), 8'(p22)};
  endfunction

  // Reference: rebuild the 3x3 grid, apply the Sobel kernels, magnitude, clamp.
  function automatic logic [7:0] ref_pix(input logic [71:0] w);
    int p[3][3];
    int gx, gy, m;
    for (int k = 0; k < 9; k++) p[k % 3][k / 3] = int'(w[71 - 8*k -: 8]);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
    m = (m >= THRESH) ? 255 : 0;
`endif
    return 8'(m);
  endfunction

  function automatic logic [71:0] rnd_win();
    logic [71:0] w;
    for (int k = 0; k < 9; k++) begin
      case ($urandom_range(3))
        0:       w[8*k +: 8] = 8'd0;
        1:       w[8*k +: 8] = 8'd255;
        default: w[8*k +: 8] = 8'($urandom);
      endcase
    end
    return w;
  endfunction

  // Scoreboard: windows enter on handshake, pixels leave on handshake in the same order.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      n_out     = 0;
      last_xfer = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(last_xfer));
      if (frame_done) fd_seen++;
      last_xfer = 1'b0;
      if (pix_valid && pix_ready) begin
        check("pixel_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check($sformatf("pix_out_n%0d", n_out), 32'(pix_out), 32'(exp_q.pop_front()));
          check($sformatf("pix_col_n%0d", n_out), 32'(pix_col), 32'(n_out % COLS));
          check($sformatf("pix_row_n%0d", n_out), 32'(pix_row), 32'((n_out / COLS) % ROWS));
        end
        last_xfer = ((n_out % FRAME) == FRAME - 1);
        n_out++;
      end
      if (win_valid && win_ready) exp_q.push_back(ref_pix(win_in));
    end
  end

  task automatic drain();
    pix_ready = 1'b1;
    win_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    step();
    check("drain_empty", 32'(exp_q.size()), 0);
    check("drain_no_valid", 32'(pix_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, cnt, n0;
    logic [7:0] held_pix, exp_v;
    logic [9:0] held_col;
    logic [8:0] held_row;

    reset = 1'b1; win_valid = 1'b0; win_in = '0; pix_ready = 1'b0;

    tab[0]  = '{mk(0,0,0, 0,0,0, 0,0,0),          8'd0,   8'd0};
    tab[1]  = '{mk(0,0,0, 0,0,0, 10,10,10),       8'd40,  8'd0};
    tab[2]  = '{mk(0,0,0, 0,0,0, 255,255,255),    8'd255, 8'd255};
    tab[3]  = '{mk(0,0,10, 0,0,10, 0,0,10),       8'd40,  8'd0};
    tab[4]  = '{mk(0,0,0, 0,0,0, 0,0,100),        8'd200, 8'd255};
    tab[5]  = '{mk(30,0,0, 0,0,0, 0,0,0),         8'd60,  8'd0};
    tab[6]  = '{mk(0,0,0, 0,0,0, 0,32,0),         8'd64,  8'd255};
    tab[7]  = '{mk(0,0,0, 0,255,0, 0,0,0),        8'd0,   8'd0};
    tab[8]  = '{mk(255,255,255, 0,0,0, 0,0,0),    8'd255, 8'd255};
    tab[9]  = '{mk(0,0,0, 0,0,0, 200,0,0),        8'd255, 8'd255};
    tab[10] = '{mk(0,31,0, 0,0,0, 0,0,0),         8'd62,  8'd0};

    // Reset state, with the downstream not ready.
    repeat (2) step();
    check("rst_pix_valid",  32'(pix_valid), 0);
    check("rst_pix_out",    32'(pix_out), 0);
    check("rst_pix_col",    32'(pix_col), 0);
    check("rst_pix_row",    32'(pix_row), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_win_ready",  32'(win_ready), 1);
    reset = 1'b0;
    pix_ready = 1'b1;
    #1;
    check("win_ready_after_release", 32'(win_ready), 1);

    // Single-window vectors: latency and value.
    for (int i = 0; i < NV; i++) begin
`ifdef SOBEL_THRESH_EN
      exp_v = tab[i].exp_thr;
`else
      exp_v = tab[i].exp_mag;
`endif
      win_in = tab[i].win; win_valid = 1'b1;
      step();
      win_valid = 1'b0;
      lat = 1;
      while (!pix_valid && lat < 10) begin step(); lat++; end
      check($sformatf("vec%0d_latency", i), 32'(lat), 3);
      check($sformatf("vec%0d_pix", i), 32'(pix_out), 32'(exp_v));
      if (i == 0) begin
        check("vec0_col", 32'(pix_col), 0);
        check("vec0_row", 32'(pix_row), 0);
      end
    end
    step();
    drain();

    // Three back-to-back windows, then a 4-cycle stall with a fourth window waiting.
    n0 = n_out;
    pix_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin win_in = rnd_win(); win_valid = 1'b1; step(); end
    win_valid = 1'b0;
    lat = 0;
    while (!pix_valid && lat < 10) begin step(); lat++; end
    check("stall_first_valid_delay", 32'(lat), 0);
    pix_ready = 1'b0;
    win_in = rnd_win(); win_valid = 1'b1;
    #1;
    held_pix = pix_out; held_col = pix_col; held_row = pix_row;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall%0d_win_ready", k), 32'(win_ready), 0);
      check($sformatf("stall%0d_pix_valid", k), 32'(pix_valid), 1);
      check($sformatf("stall%0d_pix_held", k), 32'(pix_out), 32'(held_pix));
      check($sformatf("stall%0d_col_held", k), 32'(pix_col), 32'(held_col));
      check($sformatf("stall%0d_row_held", k), 32'(pix_row), 32'(held_row));
      step();
    end
    pix_ready = 1'b1;
    step();
    win_valid = 1'b0;
    drain();
    check("stall_pixels_delivered", 32'(n_out - n0), 4);

    // Random traffic with random back-pressure.
    repeat (400) begin
      win_valid = ($urandom_range(9) < 7);
      win_in    = rnd_win();
      pix_ready = ($urandom_range(9) < 7);
      step();
    end
    drain();

    // Reset with windows in flight and a pixel waiting at the output.
    if (n_out % COLS == 0) begin
      win_in = rnd_win(); win_valid = 1'b1; step();
      drain();
    end
    pix_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin win_in = rnd_win(); win_valid = 1'b1; step(); end
    win_valid = 1'b0;
    check("pre_reset_pix_valid", 32'(pix_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pix_valid", 32'(pix_valid), 0);
    check("async_reset_pix_out",   32'(pix_out), 0);
    check("async_reset_col",       32'(pix_col), 0);
    check("async_reset_row",       32'(pix_row), 0);
    check("async_reset_win_ready", 32'(win_ready), 1);
    step(); step();
    reset = 1'b0;
    pix_ready = 1'b1;
    cnt = 0;
    repeat (5) begin step(); if (pix_valid) cnt++; end
    check("no_stale_pixel", 32'(cnt), 0);
    win_in = rnd_win(); win_valid = 1'b1;
    step();
    win_valid = 1'b0;
    lat = 1;
    while (!pix_valid && lat < 10) begin step(); lat++; end
    check("post_reset_latency", 32'(lat), 3);
    check("post_reset_col", 32'(pix_col), 0);
    check("post_reset_row", 32'(pix_row), 0);
    drain();

    // One full frame from a clean start.
    reset = 1'b1; step(); reset = 1'b0;
    fd_seen = 0;
    pix_ready = 1'b1;
    for (int k = 0; k < FRAME; k++) begin win_in = rnd_win(); win_valid = 1'b1; step(); end
    drain();
    check("frame_pixels", 32'(n_out), 32'(FRAME));
    check("frame_done_pulses", 32'(fd_seen), 1);
    check("frame_end_col", 32'(pix_col), 0);
    check("frame_end_row", 32'(pix_row), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sobel_grad.md
SOBEL_GRAD -- requirements
Module: sobel_grad

Interface
REQ-001 Parameter COLS, default 638, windows per output row (window-producer row width minus 2).
REQ-002 Parameter ROWS, default 478, output rows per frame.
REQ-003 Parameter THRESH, default 64, 8-bit binarisation threshold (used only with SOBEL_THRESH_EN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 win_in  input  72  3x3 window, column-major: [71:64]=P00,[63:56]=P10,[55:48]=P20,[47:40]=P01,[39:32]=P11,[31:24]=P21,[23:16]=P02,[15:8]=P12,[7:0]=P22 (Prc = row r, col c).
REQ-007 win_valid  input  1  win_in holds a valid window this cycle.
REQ-008 win_ready  output  1  block accepts win_in this cycle; transfer = win_valid & win_ready.
REQ-009 pix_out  output  8  gradient magnitude (or binarised edge) pixel.
REQ-010 pix_valid  output  1  pix_out valid.
REQ-011 pix_ready  input  1  downstream accepts pix_out; transfer = pix_valid & pix_ready.
REQ-012 pix_col  output  10  column index of pix_out, 0..COLS-1.
REQ-013 pix_row  output  9  row index of pix_out, 0..ROWS-1.
REQ-014 frame_done  output  1  one-cycle pulse marking end of frame.

Function
REQ-015 Gx SHALL be (P02+2*P12+P22)-(P00+2*P10+P20), computed as 11-bit signed, range -1020..1020, no overflow.
REQ-016 Gy SHALL be (P20+2*P21+P22)-(P00+2*P01+P02), computed as 11-bit signed, range -1020..1020.
REQ-017 Magnitude SHALL be |Gx|+|Gy| as 11-bit unsigned (max 2040), saturated to 255 for the 8-bit result.
REQ-018 Pipeline SHALL have 3 register stages: S1 Gx/Gy, S2 |Gx|+|Gy|, S3 saturate/threshold into pix_out.
REQ-019 With pix_ready held high, pix_valid SHALL rise exactly 3 cycles after the accepting window transfer; throughput 1 pixel/cycle.
REQ-020 Stall = pix_valid & !pix_ready; while stalled all stages, including their valid bits, SHALL hold and win_ready SHALL be 0.
REQ-021 win_ready SHALL equal !stall (combinational from registered state and pix_ready).
REQ-022 pix_out, pix_col and pix_row SHALL remain stable while pix_valid=1 and pix_ready=0.
REQ-023 Bubbles (win_valid=0) SHALL propagate as invalid stages; no pixel is emitted for them.
REQ-024 pix_col/pix_row SHALL advance on each pix transfer: col+1; at col=COLS-1 col wraps to 0 and row+1; at col=COLS-1, row=ROWS-1 both wrap to 0.
REQ-025 frame_done SHALL pulse high for exactly one cycle, the cycle after the transfer of pixel (COLS-1, ROWS-1).
REQ-026 Window transfer and pixel transfer in the same cycle SHALL both take effect (pipeline advances one slot).

Reset
REQ-027 reset high SHALL asynchronously clear all stage valid bits, pix_out=0, pix_valid=0, pix_col=0, pix_row=0, frame_done=0.
REQ-028 win_ready SHALL be 1 while reset is high and in the first cycle after release.
REQ-029 Reset mid-frame SHALL discard in-flight windows; the next accepted window is treated as pixel (0,0).

Configuration
REQ-030 Macro SOBEL_THRESH_EN defined: S3 output SHALL be 255 when saturated magnitude >= THRESH, else 0.
REQ-031 Macro SOBEL_THRESH_EN undefined: S3 output SHALL be the saturated magnitude; THRESH unused; latency unchanged.

Verification
REQ-032 All-zero window, pix_ready=1 -> pix_out=0 three cycles after transfer, pix_col=0, pix_row=0.
REQ-033 Left column 0, middle 0, right column 10 (P02=P12=P22=10), macro undefined -> Gx=40, Gy=0, pix_out=40; with macro and THRESH=64 -> pix_out=0.
REQ-034 Left column 0, right column 255 -> Gx=1020, pix_out=255 (saturated) with or without macro.
REQ-035 Three back-to-back windows, pix_ready low for 4 cycles once pix_valid rises -> win_ready=0 during stall, pix_out held, all three pixels delivered in order, none lost or duplicated.
REQ-036 COLS=4, ROWS=2, 8 windows streamed -> pix_col sequence 0,1,2,3,0,1,2,3, pix_row 0 then 1, frame_done single pulse after 8th transfer, counters back to 0.
REQ-037 reset asserted with 2 windows in flight -> pix_valid drops immediately, no stale pixel after release, next pixel reported at (0,0).
